serial_comparator_2nbit: RTL and testbench

- Sequential magnitude comparator for two 2N-bit operands.
- Uses one shared 2-bit digit compare stage and walks the operands LSB-first, one 2-bit digit per clock.
- Trades latency for area against the combinational cascaded comparator already in the design.
- Valid/ready handshake on both sides, so it sits between a register-file/operand source and a result consumer.

---
 rtl/serial_comparator_2nbit_if.sv | 27 ++
 rtl/serial_comparator_2nbit.sv | 120 ++++++++++++
 tb/tb_serial_comparator_2nbit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_2nbit_if.sv
// Handshake/operand/result bundle for serial_comparator_2nbit.
// The slave modport is the comparator side and the master modport is the
// operand source / result consumer side.
interface serial_comparator_2nbit_if #(
  parameter int N = 2
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] x_in;
  logic [2*N-1:0] y_in;
  logic           out_valid;
  logic           out_ready;
  logic           lout;
  logic           gout;
  logic           eout;
  logic           busy;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, lout, gout, eout, busy
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, lout, gout, eout, busy
  );
endinterface

// File: rtl/serial_comparator_2nbit.sv
// Sequential magnitude comparator for two 2N-bit operands.
// One shared 2-bit digit compare stage walks the operands LSB-first, one
// digit per clock, so a later (more significant) unequal digit overrides
// whatever the lower digits decided.
// Optional feature macro: SIGNED_CMP_EN -- when defined, the operands are
// treated as two's complement by inverting the digit MSBs on the final digit.
module serial_comparator_2nbit #(
  parameter int N  = 2,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst_n,
  serial_comparator_2nbit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [2*N-1:0] xs, ys;
  logic [CW-1:0]  cnt;
  logic           lt, gt;
  logic           lt_n, gt_n;
  logic           lout_q, gout_q, eout_q;
  logic [1:0]     xd, yd;
  logic           last;

  assign last = (cnt == CW'(N - 1));

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit of the top digit turns the unsigned digit compare
  // into a two's complement compare for the whole operand.
  assign xd = {xs[1] ^ last, xs[0]};
  assign yd = {ys[1] ^ last, ys[0]};
`else
  assign xd = xs[1:0];
  assign yd = ys[1:0];
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.lout      = lout_q;
  assign bus.gout      = gout_q;
  assign bus.eout      = eout_q;

  // State register; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode for the accept / walk digits / hand off result sequence.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  next_state = RUN;
      RUN:     if (last)          next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Digit compare: an unequal digit replaces the running verdict, equal holds it.
  always_comb begin
    lt_n = lt;
    gt_n = gt;
    if (xd > yd) begin
      gt_n = 1'b1;
      lt_n = 1'b0;
    end else if (xd < yd) begin
      lt_n = 1'b1;
      gt_n = 1'b0;
    end
  end

  // Operand capture, digit shifting, running verdict and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs     <= '0;
      ys     <= '0;
      cnt    <= '0;
      lt     <= 1'b0;
      gt     <= 1'b0;
      lout_q <= 1'b0;
      gout_q <= 1'b0;
      eout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xs  <= bus.x_in;
            ys  <= bus.y_in;
            cnt <= '0;
            lt  <= 1'b0;
            gt  <= 1'b0;
          end
        end
        RUN: begin
          lt  <= lt_n;
          gt  <= gt_n;
          xs  <= xs >> 2;
          ys  <= ys >> 2;
          cnt <= cnt + CW'(1);
          if (last) begin
            lout_q <= lt_n;
            gout_q <= gt_n;
            eout_q <= !(lt_n | gt_n);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator_2nbit.sv
// Bench for serial_comparator_2nbit: an N=2 instance for the directed and
// backpressure cases and an N=4 instance for random 8-bit operand pairs.
module tb_serial_comparator_2nbit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       wide = 1'b0;
  logic       drv_valid = 1'b0;
  logic       drv_ready = 1'b0;
  logic [7:0] drv_x = '0;
  logic [7:0] drv_y = '0;

  logic       sel_valid, sel_ready, sel_busy;
  logic [2:0] sel_res;

  int checks = 0;
  int errors = 0;

  serial_comparator_2nbit_if #(.N(2)) if2 ();
  serial_comparator_2nbit_if #(.N(4)) if4 ();

  serial_comparator_2nbit #(.N(2), .CW(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  serial_comparator_2nbit #(.N(4), .CW(8)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  always #5 clk = ~clk;

  // Route the single set of bench drivers to whichever instance is selected.
  assign if2.in_valid  = drv_valid & !wide;
  assign if2.out_ready = drv_ready & !wide;
  assign if2.x_in      = drv_x[3:0];
  assign if2.y_in      = drv_y[3:0];
  assign if4.in_valid  = drv_valid & wide;
  assign if4.out_ready = drv_ready & wide;
  assign if4.x_in      = drv_x;
  assign if4.y_in      = drv_y;

  assign sel_valid = wide ? if4.out_valid : if2.out_valid;
  assign sel_ready = wide ? if4.in_ready  : if2.in_ready;
  assign sel_busy  = wide ? if4.busy      : if2.busy;
  assign sel_res   = wide ? {if4.lout, if4.gout, if4.eout} : {if2.lout, if2.gout, if2.eout};

  // Reference verdict {lt, gt, eq} from plain integer comparison of w-bit operands.
  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y, input int w);
    int xv, yv;
    xv = int'(x) & ((1 << w) - 1);
    yv = int'(y) & ((1 << w) - 1);
`ifdef SIGNED_CMP_EN
    if (xv >= (1 << (w - 1))) xv = xv - (1 << w);
    if (yv >= (1 << (w - 1))) yv = yv - (1 << w);
`endif
    return {xv < yv, xv > yv, xv == yv};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Wait for out_valid with a cycle bound; returns the number of cycles waited.
  task automatic waitResult(output int cyc);
    cyc = 0;
    while (!sel_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One full transaction: accept, wait for the result, check it, hand it off.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    int cyc;
    logic [2:0] exp;
    @(negedge clk);
    checkOutput("in_ready_idle", 32'(sel_ready), 32'd1);
    drv_valid = 1'b1;
    drv_x = x;
    drv_y = y;
    @(negedge clk);
    drv_valid = 1'b0;
    drv_x = 8'($urandom);
    drv_y = 8'($urandom);
    checkOutput("busy_run", 32'(sel_busy), 32'd1);
    waitResult(cyc);
    checkOutput("latency", 32'(cyc), wide ? 32'd4 : 32'd2);
    exp = model(x, y, wide ? 8 : 4);
    checkOutput("result", 32'(sel_res), 32'(exp));
    drv_ready = 1'b1;
    @(negedge clk);
    drv_ready = 1'b0;
    checkOutput("out_valid_clear", 32'(sel_valid), 32'd0);
    checkOutput("in_ready_back", 32'(sel_ready), 32'd1);
  endtask

  // Main sequence: reset, directed cases, backpressure, mid-run reset, random.
  initial begin
    int cyc;
    logic [2:0] exp;
    logic [7:0] rx, ry;

    #12;
    checkOutput("rst_out_valid", 32'(if2.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(if2.busy), 32'd0);
    checkOutput("rst_results", 32'({if2.lout, if2.gout, if2.eout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(if2.in_ready), 32'd1);

    wide = 1'b0;
    applyStimulus(8'b1001, 8'b0110);
    applyStimulus(8'b0110, 8'b0110);
    applyStimulus(8'b0101, 8'b0110);
    applyStimulus(8'b0110, 8'b1001);
    applyStimulus(8'b1000, 8'b0001);

    // Backpressure: result must hold and a new request must be ignored.
    @(negedge clk);
    drv_valid = 1'b1;
    drv_x = 8'b1001;
    drv_y = 8'b0110;
    @(negedge clk);
    drv_valid = 1'b0;
    waitResult(cyc);
    checkOutput("bp_latency", 32'(cyc), 32'd2);
    exp = model(8'b1001, 8'b0110, 4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(sel_valid), 32'd1);
      checkOutput("bp_result", 32'(sel_res), 32'(exp));
      checkOutput("bp_in_ready", 32'(sel_ready), 32'd0);
      if (i == 1) begin
        drv_valid = 1'b1;
        drv_x = 8'b0000;
        drv_y = 8'b1111;
      end else begin
        drv_valid = 1'b0;
      end
      @(negedge clk);
    end
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    @(negedge clk);
    drv_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(sel_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(sel_ready), 32'd1);
    applyStimulus(8'b0011, 8'b1100);

    // Reset in the middle of a compare on the wide instance.
    wide = 1'b1;
    applyStimulus(8'hA5, 8'h3C);
    @(negedge clk);
    drv_valid = 1'b1;
    drv_x = 8'h12;
    drv_y = 8'h34;
    @(negedge clk);
    drv_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_abort_busy", 32'(sel_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(sel_busy), 32'd0);
    checkOutput("abort_valid", 32'(sel_valid), 32'd0);
    checkOutput("abort_results", 32'(sel_res), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_in_ready", 32'(sel_ready), 32'd1);

    // Random 8-bit pairs, with every fourth pair forced equal.
    for (int k = 0; k < 40; k++) begin
      rx = 8'($urandom);
      ry = (k % 4 == 3) ? rx : 8'($urandom);
      applyStimulus(rx, ry);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
